// File: rtl/mnist_pkg.sv
// Shared MNIST constants: class count, argmax FSM states and active-low
// 7-segment codes {dp,g,f,e,d,c,b,a}.
package mnist_pkg;

  localparam int CLASSES = 10;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } argmax_state_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/mnist_argmax_classifier_if.sv
// Serial class-score stream from the systolic array into the argmax stage.
// Handshake: a beat transfers on a rising edge where score_valid && score_ready;
// score must hold while score_valid is high and the beat has not transferred.
interface mnist_argmax_classifier_if #(
  parameter int SCORE_WIDTH = 32
);
  logic                   score_valid;
  logic [SCORE_WIDTH-1:0] score;
  logic                   score_ready;

  modport master (output score_valid, output score, input score_ready);
  modport slave  (input score_valid, input score, output score_ready);
endinterface

// File: rtl/seg7_decoder.sv
// Combinational 4-bit index to active-low 7-segment code; values above 9 blank.
module seg7_decoder
  import mnist_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (idx)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mnist_argmax_classifier.sv
// Argmax over CLASSES serial signed scores; registers one-hot/hex/ready on DONE entry.
// Optional runner-up tracking and low-confidence flag: define MNIST_ARGMAX_CONF_EN.
module mnist_argmax_classifier #(
  parameter int SCORE_WIDTH = 32,
  parameter int CLASSES     = 10,
  parameter int CONF_THRESH = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  mnist_argmax_classifier_if.slave  score_if,
  output logic                      ready,
  output logic [CLASSES-1:0]        classes,
  output logic [3:0]                class_idx,
  output logic [SCORE_WIDTH-1:0]    max_score,
  output logic [7:0]                hex_connect,
  output logic                      low_conf,
  output mnist_pkg::argmax_state_t  state
);
  import mnist_pkg::*;

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(CLASSES - 1);
  localparam logic [CLASSES-1:0] ONE_HOT0 = CLASSES'(1);

  logic                   accept;
  logic                   first;
  logic [SCORE_WIDTH-1:0] nxt_max;
  logic [IDX_W-1:0]       nxt_idx;
  logic [IDX_W-1:0]       cnt;
  logic [7:0]             nxt_hex;
  logic                   nxt_low;

  assign score_if.score_ready = (state == COLLECT);
  // start has priority: a score presented alongside start is never taken.
  assign accept = score_if.score_valid && score_if.score_ready && !start;
  assign first  = (cnt == '0);

  always_comb begin
    nxt_max = max_score;
    nxt_idx = class_idx;
    if (first || ($signed(score_if.score) > $signed(max_score))) begin
      nxt_max = score_if.score;
      nxt_idx = cnt;
    end
  end

`ifdef MNIST_ARGMAX_CONF_EN
  localparam logic [SCORE_WIDTH-1:0] MOST_NEG = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
  localparam logic signed [SCORE_WIDTH:0] THRESH = (SCORE_WIDTH+1)'(CONF_THRESH);

  logic [SCORE_WIDTH-1:0]        second;
  logic [SCORE_WIDTH-1:0]        nxt_second;
  logic signed [SCORE_WIDTH:0]   margin;

  always_comb begin
    nxt_second = second;
    if (first) begin
      nxt_second = MOST_NEG;
    end else if ($signed(score_if.score) > $signed(max_score)) begin
      nxt_second = max_score;
    end else if ($signed(score_if.score) > $signed(second)) begin
      nxt_second = score_if.score;
    end
    // One extra bit so max minus most-negative runner-up cannot overflow.
    margin  = $signed({nxt_max[SCORE_WIDTH-1], nxt_max})
            - $signed({nxt_second[SCORE_WIDTH-1], nxt_second});
    nxt_low = (margin < THRESH);
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      second <= MOST_NEG;
    end else if (accept) begin
      second <= nxt_second;
    end
  end
`else
  // Without runner-up tracking the flag is constant; a sane threshold is never negative.
  assign nxt_low = (CONF_THRESH < 0);
`endif

  seg7_decoder u_seg7 (
    .idx (nxt_idx),
    .seg (nxt_hex)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      max_score   <= '0;
      class_idx   <= '0;
      ready       <= 1'b0;
      classes     <= '0;
      hex_connect <= SEG_BLANK;
      low_conf    <= 1'b0;
    end else if (start) begin
      state     <= COLLECT;
      cnt       <= '0;
      max_score <= '0;
      class_idx <= '0;
      // Aborting in COLLECT leaves the published result untouched.
      if (state == DONE) begin
        ready       <= 1'b0;
        classes     <= '0;
        hex_connect <= SEG_BLANK;
      end
    end else if (accept) begin
      max_score <= nxt_max;
      class_idx <= nxt_idx;
      if (cnt == LAST_IDX) begin
        state       <= DONE;
        cnt         <= '0;
        ready       <= 1'b1;
        classes     <= ONE_HOT0 << nxt_idx;
        hex_connect <= nxt_hex;
        low_conf    <= nxt_low;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mnist_argmax_classifier.sv
// Directed bench for mnist_argmax_classifier with an expected-result queue
// drained by a monitor on each rising edge of ready.
module tb_mnist_argmax_classifier;
  import mnist_pkg::*;

  localparam int W     = 32;
  localparam int NC    = 10;
  localparam int EXP_W = NC + 4 + W + 8 + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          ready;
  logic [NC-1:0] classes;
  logic [3:0]    class_idx;
  logic [W-1:0]  max_score;
  logic [7:0]    hex_connect;
  logic          low_conf;
  argmax_state_t dbg_state;

  mnist_argmax_classifier_if #(.SCORE_WIDTH(W)) sif ();

  mnist_argmax_classifier #(
    .SCORE_WIDTH (W),
    .CLASSES     (NC),
    .CONF_THRESH (256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .score_if    (sif),
    .ready       (ready),
    .classes     (classes),
    .class_idx   (class_idx),
    .max_score   (max_score),
    .hex_connect (hex_connect),
    .low_conf    (low_conf),
    .state       (dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;
  int last_acc_edge = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_expect(input int idx, input logic [W-1:0] mx, input logic lc_en);
    logic [NC-1:0] oh;
    logic          lc;
    oh = '0;
    oh[idx] = 1'b1;
`ifdef MNIST_ARGMAX_CONF_EN
    lc = lc_en;
`else
    lc = 1'b0 & lc_en;
`endif
    exp_q.push_back({oh, 4'(idx), mx, seg_tab[idx], lc});
  endtask

  // Scoreboard monitor
  logic ready_q = 1'b0;
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (ready && !ready_q) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_ready: ready rose with no image pending (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("classes",     64'(classes),     64'(e[EXP_W-1 -: NC]));
        check("class_idx",   64'(class_idx),   64'(e[W+8+1 +: 4]));
        check("max_score",   64'(max_score),   64'(e[8+1 +: W]));
        check("hex_connect", 64'(hex_connect), 64'(e[1 +: 8]));
        check("low_conf",    64'(low_conf),    64'(e[0]));
        check("latency",     64'(cyc),         64'(last_acc_edge));
        check("score_ready_in_done", 64'(sif.score_ready), 64'(0));
      end
    end
    ready_q <= ready;
  end

  // Driver tasks
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_score(input logic [W-1:0] v);
    int guard;
    guard = 0;
    sif.score_valid = 1'b1;
    sif.score       = v;
    while (!sif.score_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!sif.score_ready) begin
      compared++;
      mismatched++;
      $display("FAIL score_ready_timeout: score_ready %0b after %0d cycles, required 1", sif.score_ready, guard);
    end else begin
      last_acc_edge = cyc + 1;
      @(posedge clk); #1;
    end
    sif.score_valid = 1'b0;
  endtask

  task automatic send_image(input logic [W-1:0] sc [NC], input int gap);
    for (int i = 0; i < NC; i++) begin
      send_score(sc[i]);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ready) begin
      compared++;
      mismatched++;
      $display("FAIL wait_ready_timeout: ready %0b after %0d cycles, required 1", ready, guard);
    end
    @(negedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},       64'(ready),           64'(0));
    check({tag, "_score_ready"}, 64'(sif.score_ready), 64'(0));
    check({tag, "_classes"},     64'(classes),         64'(0));
    check({tag, "_class_idx"},   64'(class_idx),       64'(0));
    check({tag, "_max_score"},   64'(max_score),       64'(0));
    check({tag, "_hex"},         64'(hex_connect),     64'h0FF);
    check({tag, "_low_conf"},    64'(low_conf),        64'(0));
    check({tag, "_state"},       64'(dbg_state),       64'(IDLE));
  endtask

  logic [W-1:0] img [NC];

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sif.score_valid = 1'b0;
    sif.score = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    // Basic argmax at full rate
    pulse_start();
    check("score_ready_after_start", 64'(sif.score_ready), 64'(1));
    push_expect(2, 100, 1'b1);
    img = '{5, -3, 100, 7, 0, 2, 1, 9, 99, 4};
    send_image(img, 0);
    wait_ready();

    // Scores offered in DONE are ignored
    sif.score_valid = 1'b1;
    sif.score = 32'd1000;
    repeat (2) begin
      @(posedge clk); #1;
    end
    sif.score_valid = 1'b0;
    check("done_ignore_ready", 64'(ready),     64'(1));
    check("done_ignore_idx",   64'(class_idx), 64'(2));
    check("done_ignore_max",   64'(max_score), 64'(100));

    // start in DONE clears the published result
    pulse_start();
    check("restart_ready",   64'(ready),       64'(0));
    check("restart_classes", 64'(classes),     64'(0));
    check("restart_hex",     64'(hex_connect), 64'h0FF);
    check("restart_state",   64'(dbg_state),   64'(COLLECT));

    // All-equal scores: lowest index wins
    push_expect(0, -20, 1'b1);
    img = '{-20, -20, -20, -20, -20, -20, -20, -20, -20, -20};
    send_image(img, 0);
    wait_ready();

    // Gapped valid, extreme positive max at the last index
    pulse_start();
    push_expect(9, 32'h7FFF_FFFF, 1'b0);
    img = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 32'h7FFF_FFFF};
    send_image(img, 1);
    wait_ready();

    // Abort after 4 scores; the abort start coincides with a valid score
    pulse_start();
    img = '{800, 900, 1000, 1100, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) send_score(img[i]);
    sif.score_valid = 1'b1;
    sif.score = 32'h7FFF_FFF0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sif.score_valid = 1'b0;
    check("abort_ready", 64'(ready), 64'(0));
    push_expect(6, 50, 1'b1);
    img = '{1, 2, 3, 4, 5, 6, 50, 7, 8, 9};
    send_image(img, 0);
    wait_ready();

    // Reset mid-image, then a clean image
    pulse_start();
    img = '{11, 12, 13, 14, 15, 16, 17, 0, 0, 0};
    for (int i = 0; i < 7; i++) send_score(img[i]);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midreset");
    reset = 1'b0;
    pulse_start();
    push_expect(3, 40, 1'b1);
    img = '{-5, -6, -7, 40, -1, 0, 3, 2, 1, -9};
    send_image(img, 0);
    wait_ready();

    // Confidence margins: 1000 vs 900 and 1000 vs 500
    pulse_start();
    push_expect(4, 1000, 1'b1);
    img = '{0, 900, 0, 0, 1000, 0, 0, 0, 0, 0};
    send_image(img, 0);
    wait_ready();

    pulse_start();
    push_expect(7, 1000, 1'b0);
    img = '{0, 0, 500, 0, 0, 0, 0, 1000, 0, 0};
    send_image(img, 0);
    wait_ready();

    check("pending_results", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
